// File: rtl/mem_fetch_unit.sv
// -----------------------------------------------------------------------------
// mem_fetch_unit
//
// Memory-access and instruction-register stage that sits between Control and
// the unified instruction/data memory. It accepts a read or write request from
// Control and runs a req/ack handshake with a variable-latency memory. A
// completed fetch is latched into IR, which drives OPcode/Imm back to Control.
// Load data is latched into MDR. Stall holds Control in its current state
// until the access has completed.
//
// Optional feature (compile-time macro MEMFETCH_TIMEOUT_EN):
//   When defined, an access that is still waiting for ack after TIMEOUT_CYC
//   REQ cycles is abandoned. mem_req drops, MDR is cleared and the sticky
//   mem_err flag is set. An ack that arrives in the timeout cycle still wins.
//   When undefined, REQ waits indefinitely and mem_err is constant 0.
//
// Parameters:
//   DATA_W       memory word / IR / MDR / address width
//   OP_W         opcode field width, taken from IR[DATA_W-1 -: OP_W]
//   TIMEOUT_CYC  wait-cycle limit (exists only with MEMFETCH_TIMEOUT_EN)
//
// Ports:
//   CLK, Reset          rising-edge clock, synchronous active-high reset
//   MemRead, MemWrite   access requests from Control (write wins if both set)
//   IorD                address select: 0 = PC, 1 = ALUOut
//   IRenable            read data is an instruction fetch (load IR)
//   PC, ALUOut          candidate addresses
//   WriteData           store data
//   mem_addr, mem_wdata registered address / store data to memory
//   mem_req, mem_we     request (held until ack) and write enable
//   mem_rdata, mem_ack  read data and one-cycle completion pulse from memory
//   OPcode, Imm         IR fields to Control
//   MDR                 memory data register
//   Stall               combinational hold request to Control
//   mem_err             sticky timeout flag
// -----------------------------------------------------------------------------
module mem_fetch_unit #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5
`ifdef MEMFETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic                   IorD,
  input  logic                   IRenable,
  input  logic [DATA_W-1:0]      PC,
  input  logic [DATA_W-1:0]      ALUOut,
  input  logic [DATA_W-1:0]      WriteData,
  output logic [DATA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_req,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack,
  output logic [OP_W-1:0]        OPcode,
  output logic [DATA_W-OP_W-1:0] Imm,
  output logic [DATA_W-1:0]      MDR,
  output logic                   Stall,
  output logic                   mem_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   ir_r;
  logic                ir_pend_r;   // the outstanding read is an instruction fetch
  logic                start_s;
  logic                timeout_s;
  logic                stall_s;

  assign start_s = MemRead | MemWrite;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and Stall generation.
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_REQ;
          stall_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          stall_s = 1'b0;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (mem_ack | timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_REQ;
        end
      end
      // DONE releases Control for exactly one cycle so it can advance.
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign Stall = stall_s;

  // Memory interface, IR and MDR registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      mem_addr  <= {DATA_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      ir_pend_r <= 1'b0;
      ir_r      <= {DATA_W{1'b0}};
      MDR       <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            mem_addr  <= IorD ? ALUOut : PC;
            mem_wdata <= WriteData;
            mem_we    <= MemWrite;
            // A write overrides a simultaneous read, so it never loads IR.
            ir_pend_r <= IRenable & ~MemWrite;
            mem_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              MDR <= mem_rdata;
              if (ir_pend_r) begin
                ir_r <= mem_rdata;
              end
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (timeout_s) begin
            // Abandoned access: IR keeps the last good instruction.
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            MDR     <= {DATA_W{1'b0}};
          end
        end
        ST_DONE: begin
          mem_req <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign OPcode = ir_r[DATA_W-1 -: OP_W];
  assign Imm    = ir_r[DATA_W-OP_W-1:0];

`ifdef MEMFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt_r;
  logic             mem_err_r;

  assign timeout_s = (state_r == ST_REQ) && (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  assign mem_err   = mem_err_r;

  // Wait counter: zero outside REQ, so it starts at 0 on every REQ entry.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Sticky timeout flag; an ack in the timeout cycle counts as success.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      mem_err_r <= 1'b0;
    end else if (timeout_s && !mem_ack) begin
      mem_err_r <= 1'b1;
    end else begin
      mem_err_r <= mem_err_r;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_fetch_unit
//
// Self-checking bench for mem_fetch_unit. A transaction-level reference model
// (one outstanding access record plus the architectural IR/MDR/err values)
// is advanced every clock from the same inputs the DUT sees. One compare
// process checks all outputs against it on every falling edge. Directed
// scenarios pin the model with literal expectations, then a long randomized
// run with random memory latencies, spurious acks and random resets follows.
// -----------------------------------------------------------------------------
module tb_mem_fetch_unit;

  localparam int DATA_W = 16;
  localparam int OP_W   = 5;
`ifdef MEMFETCH_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 15;
`endif

  logic              CLK       = 1'b0;
  logic              Reset     = 1'b1;
  logic              MemRead   = 1'b0;
  logic              MemWrite  = 1'b0;
  logic              IorD      = 1'b0;
  logic              IRenable  = 1'b0;
  logic [DATA_W-1:0] PC        = 16'h0000;
  logic [DATA_W-1:0] ALUOut    = 16'h0000;
  logic [DATA_W-1:0] WriteData = 16'h0000;
  logic [DATA_W-1:0] mem_rdata = 16'h0000;
  logic              mem_ack   = 1'b0;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [OP_W-1:0]   OPcode;
  logic [DATA_W-OP_W-1:0] Imm;
  logic [DATA_W-1:0] MDR;
  logic              Stall;
  logic              mem_err;

  int checks = 0;
  int errors = 0;

  mem_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRenable(IRenable), .PC(PC), .ALUOut(ALUOut),
    .WriteData(WriteData), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .OPcode(OPcode), .Imm(Imm), .MDR(MDR),
    .Stall(Stall), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid  = 1'b0;  // model is meaningful once a reset edge was seen
  bit          m_busy   = 1'b0;  // an access is outstanding at the memory
  bit          m_after  = 1'b0;  // the quiet cycle following a finished access
  int          m_waited = 0;     // cycles the outstanding access has waited
  bit          m_we     = 1'b0;
  bit          m_fetch  = 1'b0;
  logic [15:0] m_addr   = 16'h0000;
  logic [15:0] m_wdata  = 16'h0000;
  logic [15:0] m_ir     = 16'h0000;
  logic [15:0] m_mdr    = 16'h0000;
  bit          m_err    = 1'b0;

  always @(posedge CLK) begin
    if (Reset) begin
      m_valid <= 1'b1; m_busy <= 1'b0; m_after <= 1'b0; m_waited <= 0;
      m_we <= 1'b0; m_fetch <= 1'b0; m_addr <= 16'h0000; m_wdata <= 16'h0000;
      m_ir <= 16'h0000; m_mdr <= 16'h0000; m_err <= 1'b0;
    end else if (m_after) begin
      m_after <= 1'b0;
    end else if (m_busy) begin
      if (mem_ack) begin
        if (!m_we) begin
          m_mdr <= mem_rdata;
          if (m_fetch) m_ir <= mem_rdata;
        end
        m_busy <= 1'b0; m_after <= 1'b1;
`ifdef MEMFETCH_TIMEOUT_EN
      end else if (m_waited == TIMEOUT_CYC - 1) begin
        m_busy <= 1'b0; m_after <= 1'b1; m_mdr <= 16'h0000; m_err <= 1'b1;
`endif
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (MemRead || MemWrite) begin
      m_busy   <= 1'b1;
      m_waited <= 0;
      m_addr   <= IorD ? ALUOut : PC;
      m_wdata  <= WriteData;
      m_we     <= MemWrite;
      m_fetch  <= IRenable && !MemWrite;
    end
  end

  // Single compare process: every output against the model, every cycle.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("mem_req", 32'(mem_req), 32'(m_busy));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      if (m_busy) chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("OPcode", 32'(OPcode), 32'(m_ir[15:11]));
      chk("Imm", 32'(Imm), 32'(m_ir[10:0]));
      chk("MDR", 32'(MDR), 32'(m_mdr));
      chk("mem_err", 32'(mem_err), 32'(m_err));
      chk("Stall", 32'(Stall), 32'(m_busy || (!m_after && (MemRead || MemWrite))));
    end
  end

  // ---------------- memory responder + driver ----------------
  int          resp_wait = 0;      // REQ cycles before ack; -1 = never ack
  logic [15:0] resp_data = 16'h0000;
  int          req_age   = 0;
  bit          spur_en   = 1'b0;   // allow random acks while no request is up

  task automatic tick();
    @(posedge CLK);
    #1;
    if (mem_req === 1'b1) begin
      if (resp_wait >= 0 && req_age == resp_wait) begin
        mem_ack = 1'b1; mem_rdata = resp_data;
      end else begin
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
      end
      req_age++;
    end else begin
      req_age   = 0;
      mem_ack   = spur_en && ($urandom_range(0, 5) == 0);
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic iord, input logic iren,
                        input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                        input int waits, input logic [15:0] rdata,
                        output int stalls, output int req_cycles,
                        output logic [15:0] addr_seen, output logic [15:0] wdata_seen,
                        output logic we_seen);
    resp_wait = waits; resp_data = rdata;
    MemRead = rd; MemWrite = wr; IorD = iord; IRenable = iren;
    PC = pc; ALUOut = alu; WriteData = wd;
    stalls = 0; req_cycles = 0;
    addr_seen = 16'h0000; wdata_seen = 16'h0000; we_seen = 1'b0;
    #1;
    while (Stall === 1'b1 && stalls < 40) begin
      stalls++;
      if (mem_req === 1'b1) begin
        req_cycles++;
        addr_seen = mem_addr; wdata_seen = mem_wdata; we_seen = mem_we;
      end
      tick();
    end
    MemRead = 1'b0; MemWrite = 1'b0; IRenable = 1'b0;
    tick();
  endtask

  initial begin
    int          st;
    int          rq;
    logic [15:0] a;
    logic [15:0] w;
    logic        we;

    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_OPcode", 32'(OPcode), 32'h0);
    chk("rst_MDR", 32'(MDR), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Instruction fetch, zero-wait memory.
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h5823, st, rq, a, w, we);
    chk("fetch_stalls", 32'(st), 32'd2);
    chk("fetch_addr", 32'(a), 32'h0010);
    chk("fetch_we", 32'(we), 32'h0);
    chk("fetch_OPcode", 32'(OPcode), 32'h0B);
    chk("fetch_Imm", 32'(Imm), 32'h023);
    chk("fetch_MDR", 32'(MDR), 32'h5823);
    chk("model_ir", 32'(m_ir), 32'h5823);

    // Load with three wait cycles.
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0200, 16'h0000, 3, 16'hBEEF, st, rq, a, w, we);
    chk("load_stalls", 32'(st), 32'd5);
    chk("load_req_held", 32'(rq), 32'd4);
    chk("load_addr", 32'(a), 32'h0200);
    chk("load_MDR", 32'(MDR), 32'hBEEF);
    chk("load_OPcode", 32'(OPcode), 32'h0B);

    // Store: MDR and IR must not move even though rdata toggles.
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0012, 16'h0300, 16'h1234, 0, 16'hFFFF, st, rq, a, w, we);
    chk("store_stalls", 32'(st), 32'd2);
    chk("store_we", 32'(we), 32'h1);
    chk("store_addr", 32'(a), 32'h0300);
    chk("store_wdata", 32'(w), 32'h1234);
    chk("store_MDR", 32'(MDR), 32'hBEEF);
    chk("store_Imm", 32'(Imm), 32'h023);

    // Read and write together: the write wins.
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0013, 16'h0400, 16'h00AA, 1, 16'h7777, st, rq, a, w, we);
    chk("both_stalls", 32'(st), 32'd3);
    chk("both_we", 32'(we), 32'h1);
    chk("both_MDR", 32'(MDR), 32'hBEEF);
    chk("both_OPcode", 32'(OPcode), 32'h0B);

    // Spurious ack while idle.
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    chk("spur_MDR", 32'(MDR), 32'hBEEF);
    chk("spur_OPcode", 32'(OPcode), 32'h0B);
    chk("spur_req", 32'(mem_req), 32'h0);

`ifdef MEMFETCH_TIMEOUT_EN
    // Memory never answers: abandon after 15 REQ cycles.
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0000, -1, 16'h0000, st, rq, a, w, we);
    chk("to_stalls", 32'(st), 32'd16);
    chk("to_req_cycles", 32'(rq), 32'd15);
    chk("to_err", 32'(mem_err), 32'h1);
    chk("to_MDR", 32'(MDR), 32'h0);
    chk("to_OPcode", 32'(OPcode), 32'h0B);
`else
    // Slow memory: REQ waits as long as it takes.
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0500, 16'h0000, 20, 16'hCAFE, st, rq, a, w, we);
    chk("slow_stalls", 32'(st), 32'd22);
    chk("slow_MDR", 32'(MDR), 32'hCAFE);
    chk("slow_err", 32'(mem_err), 32'h0);
`endif

    // Reset during REQ with an ack in the same cycle.
    resp_wait = 0; resp_data = 16'h9999;
    MemRead = 1'b1; IorD = 1'b0; IRenable = 1'b1; PC = 16'h0040;
    tick();
    chk("rreq_req", 32'(mem_req), 32'h1);
    Reset = 1'b1; MemRead = 1'b0; IRenable = 1'b0;
    tick();
    chk("rreq_mem_req", 32'(mem_req), 32'h0);
    chk("rreq_OPcode", 32'(OPcode), 32'h0);
    chk("rreq_MDR", 32'(MDR), 32'h0);
    chk("rreq_Stall", 32'(Stall), 32'h0);
    chk("rreq_err", 32'(mem_err), 32'h0);
    Reset = 1'b0;
    tick();

`ifdef MEMFETCH_TIMEOUT_EN
    // Ack on the 15th REQ cycle beats the timeout.
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0050, 16'h0000, 16'h0000, 14, 16'h4321, st, rq, a, w, we);
    chk("late_stalls", 32'(st), 32'd16);
    chk("late_err", 32'(mem_err), 32'h0);
    chk("late_MDR", 32'(MDR), 32'h4321);
    chk("late_OPcode", 32'(OPcode), 32'h08);
`endif

    // Randomized run against the model.
    spur_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      int r;
      Reset     = ($urandom_range(0, 99) == 0);
      MemRead   = ($urandom_range(0, 2) == 0);
      MemWrite  = ($urandom_range(0, 3) == 0);
      IorD      = 1'($urandom);
      IRenable  = 1'($urandom);
      PC        = 16'($urandom);
      ALUOut    = 16'($urandom);
      WriteData = 16'($urandom);
      if (mem_req !== 1'b1) begin
        r = int'($urandom_range(0, 9));
`ifdef MEMFETCH_TIMEOUT_EN
        resp_wait = (r < 7) ? r : (r == 7) ? 13 : (r == 8) ? 14 : -1;
`else
        resp_wait = (r < 9) ? r : 25;
`endif
        resp_data = 16'($urandom);
      end
      tick();
    end

    Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; spur_en = 1'b0;
    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so a wedged run still ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_fetch_unit.md
Name: mem_fetch_unit

Overview:
- Memory-access and instruction-register stage between Control and the unified instruction/data memory.
- Consumes Control's MemRead, MemWrite, IorD and IRenable.
- Runs a req/ack handshake with a variable-latency memory.
- Latches instructions into IR, driving OPcode and Imm back to Control, and latches load data into MDR.
- Raises Stall so Control holds its current state until the access completes.

Parameters:
- DATA_W, 16, width of the memory word, IR, MDR and address.
- OP_W, 5, opcode field width, taken from IR[DATA_W-1 -: OP_W].
- TIMEOUT_CYC, 15, wait-cycle limit, used only with MEMFETCH_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- MemRead  in  1  Control read request.
- MemWrite  in  1  Control write request.
- IorD  in  1  address select: 0 = PC, 1 = ALUOut.
- IRenable  in  1  read data goes to IR (fetch).
- PC  in  DATA_W  program counter.
- ALUOut  in  DATA_W  data address.
- WriteData  in  DATA_W  store data.
- mem_addr  out  DATA_W  registered memory address.
- mem_wdata  out  DATA_W  registered store data.
- mem_req  out  1  request, held until ack.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_rdata  in  DATA_W  read data, valid on the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- OPcode  out  OP_W  IR opcode field to Control.
- Imm  out  DATA_W-OP_W  IR low field.
- MDR  out  DATA_W  memory data register.
- Stall  out  1  Control must hold its state.
- mem_err  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - IR=0, so OPcode=0 and Imm=0.
  - MDR=0, mem_err=0.
  - Reset mid-transaction drops mem_req the next edge and discards any ack arriving in that same cycle.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If MemRead|MemWrite: latch mem_addr = IorD ? ALUOut : PC, mem_wdata = WriteData, mem_we = MemWrite, and a pending-IR flag = IRenable & ~MemWrite.
  - Then set mem_req=1 and go to REQ.
  - MemWrite wins when both are asserted (the read is ignored).
  - mem_ack is ignored in IDLE.
- REQ:
  - mem_req=1; address, wdata and we stay stable.
  - On mem_ack:
    - For a read, MDR<=mem_rdata; if the pending-IR flag is set, IR<=mem_rdata too.
    - For a write, MDR is unchanged.
    - mem_req<=0, go to DONE.
- DONE:
  - Lasts one cycle, then go to IDLE.
  - MemRead/MemWrite are ignored; Control is still presenting the same state's signals.
- Stall is combinational = (IDLE & (MemRead|MemWrite)) | REQ. It is 0 in DONE.
- Latency with a zero-wait memory (ack in the first REQ cycle): Stall high for 2 cycles; Control advances on the DONE edge; IR/MDR updated at the start of DONE.
- With N wait cycles: Stall high for 2+N cycles.
- OPcode and Imm are pure slices of IR. IR changes only on a completed fetch, so OPcode is stable through decode/execute.
- When IRenable=1 with MemRead=0, IR is not loaded.

Optional Feature:
- Macro MEMFETCH_TIMEOUT_EN.
- Defined:
  - A wait counter starts at 0 on entry to REQ and increments each cycle without ack.
  - At count == TIMEOUT_CYC-1 without ack: mem_req<=0, MDR<=0, IR unchanged, mem_err<=1 (sticky until Reset), go to DONE.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; mem_err is constant 0.

Test Plan:
- Reset, then fetch: PC=0x0010, MemRead=1, IorD=0, IRenable=1; ack on the 1st REQ cycle with rdata=0x5823 -> mem_addr=0x0010, mem_we=0, Stall high for 2 cycles, OPcode=5'b01011, Imm=0x023, MDR=0x5823.
- Load with 3 wait cycles: IorD=1, ALUOut=0x0200, IRenable=0, rdata=0xBEEF -> Stall high for 5 cycles, MDR=0xBEEF, OPcode unchanged, mem_req held through all waits.
- Store: MemWrite=1, IorD=1, ALUOut=0x0300, WriteData=0x1234 -> mem_we=1, mem_wdata=0x1234, MDR and IR unchanged, Stall drops in DONE.
- MemRead and MemWrite both 1 -> write performed, mem_we=1, IR/MDR unchanged. Spurious mem_ack in IDLE -> no register change.
- Reset asserted in REQ with ack in the same cycle -> next edge: mem_req=0, IR=0, MDR=0, state IDLE, Stall=0.
- With MEMFETCH_TIMEOUT_EN and no ack -> after 15 REQ cycles: mem_req=0, mem_err=1, MDR=0. Ack on the 15th cycle instead -> normal completion, mem_err=0.
